// File: rtl/mouse_pkg.sv
// mouse_pkg: shared types and constants for the PS/2 mouse front end.
//   ps2_state_t    - frame deframer states
//   BTN_L..YO      - bit positions inside the first (status) byte of a packet
//   PS2_FILTER_LEN - consecutive equal samples needed to accept a ps2_clk level
//   clamp_axis     - saturate a signed 14-bit coordinate into 0..max
package mouse_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned SYNC  = 3;
  localparam int unsigned XS    = 4;
  localparam int unsigned YS    = 5;
  localparam int unsigned XO    = 6;
  localparam int unsigned YO    = 7;

  localparam int unsigned PS2_FILTER_LEN = 4;

  function automatic logic [11:0] clamp_axis(input logic signed [13:0] v,
                                             input logic [11:0]        max);
    logic signed [13:0] max_s;
    max_s = $signed({2'b00, max});
    if (v < 14'sd0)     return 12'd0;
    else if (v > max_s) return max;
    else                return v[11:0];
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host byte receiver.
//   Synchronises ps2_clk/ps2_data, debounces ps2_clk, deframes
//   start/8 data/parity/stop and aborts stalled frames or packets.
// Ports:
//   clk, rst        - system clock, async active-low reset
//   ps2_clk/data    - raw pad inputs
//   pkt_busy        - packet assembler is mid-packet (keeps the timer armed)
//   rx_byte         - last received byte, valid while byte_valid is high
//   byte_valid      - one-cycle pulse, the cycle after the stop-bit strobe
//   frame_err       - one-cycle pulse on a framing error, parity error or timeout
//   pkt_abort       - one-cycle pulse telling the assembler to restart at byte 0
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_rx_frame
  import mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pkt_busy,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       pkt_abort
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]                clk_sync_q, clk_sync_d;
  logic [1:0]                dat_sync_q, dat_sync_d;
  logic [PS2_FILTER_LEN-1:0] hist_q, hist_d;
  logic                      clk_filt_q, clk_filt_d;
  ps2_state_t                state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shift_q, shift_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      byte_valid_q, byte_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      pkt_abort_q, pkt_abort_d;
  logic                      strobe, din;
`ifdef PS2_PARITY_CHECK_EN
  logic                      parity_q, parity_d;
`endif

  always_comb begin
    clk_sync_d   = {clk_sync_q[0], ps2_clk};
    dat_sync_d   = {dat_sync_q[0], ps2_data};
    hist_d       = {hist_q[PS2_FILTER_LEN-2:0], clk_sync_q[1]};
    // Filtered level only moves once the last PS2_FILTER_LEN samples agree.
    clk_filt_d   = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : clk_filt_q;
    strobe       = clk_filt_q & ~clk_filt_d;
    din          = dat_sync_q[1];
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    pkt_abort_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d     = parity_q;
`endif

    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (!din) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = din;
`endif
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (din) begin
`ifdef PS2_PARITY_CHECK_EN
            if (^{shift_q, parity_q}) begin
              byte_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              pkt_abort_d = 1'b1;
            end
`else
            byte_valid_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end

    // A strobe always restarts the timer, so it beats a coincident expiry.
    if (strobe) begin
      timer_d = '0;
    end else if (state_q != IDLE || pkt_busy) begin
      if (timer_q == T_LAST) begin
        timer_d     = '0;
        state_d     = IDLE;
        frame_err_d = 1'b1;
        pkt_abort_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      hist_q       <= '1;
      clk_filt_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      timer_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      pkt_abort_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      hist_q       <= hist_d;
      clk_filt_q   <= clk_filt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      pkt_abort_q  <= pkt_abort_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign pkt_abort  = pkt_abort_q;

endmodule

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder: PS/2 mouse stream-mode packet decoder.
//   Assembles 3-byte packets from ps2_rx_frame and integrates the signed
//   deltas into clamped absolute coordinates (Y grows downward on screen).
// Ports:
//   clk, rst                - system clock, async active-low reset
//   ps2_clk, ps2_data       - raw PS/2 pad inputs
//   mouse_xpos/mouse_ypos   - absolute position, 0..X_MAX / 0..Y_MAX
//   left_mouse/right_mouse  - button state from the last valid packet
//   packet_valid            - one-cycle pulse when position/buttons update
//   frame_err               - one-cycle pulse on any frame/packet abort
// Build option: PS2_PARITY_CHECK_EN (see ps2_rx_frame).
module ps2_mouse_decoder
  import mouse_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 65_000_000,
  parameter int X_MAX          = 1023,
  parameter int Y_MAX          = 767,
  parameter int X_INIT         = 512,
  parameter int Y_INIT         = 384,
  parameter int TIMEOUT_CYCLES = 130_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] mouse_xpos,
  output logic [11:0] mouse_ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        packet_valid,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid, pkt_abort;

  logic [1:0]  pkt_idx_q, pkt_idx_d;
  logic        l_q, l_d, r_q, r_d, xs_q, xs_d, ys_q, ys_d, xo_q, xo_d, yo_q, yo_d;
  logic [7:0]  dx_q, dx_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        left_q, left_d, right_q, right_d, pv_q, pv_d;
  logic signed [13:0] dx_s, dy_s, x_sum, y_sum;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .pkt_busy  (pkt_idx_q != 2'd0),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .pkt_abort (pkt_abort)
  );

  always_comb begin
    pkt_idx_d = pkt_idx_q;
    l_d = l_q;  r_d = r_q;  xs_d = xs_q;  ys_d = ys_q;  xo_d = xo_q;  yo_d = yo_q;
    dx_d      = dx_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    left_d    = left_q;
    right_d   = right_q;
    pv_d      = 1'b0;
    // 9-bit two's-complement deltas widened to 14 bits; overflow zeroes the axis.
    dx_s  = xo_q ? 14'sd0 : $signed({{6{xs_q}}, dx_q});
    dy_s  = yo_q ? 14'sd0 : $signed({{6{ys_q}}, rx_byte});
    x_sum = $signed({2'b00, xpos_q}) + dx_s;
    y_sum = $signed({2'b00, ypos_q}) - dy_s;

    if (pkt_abort) begin
      pkt_idx_d = 2'd0;
    end else if (byte_valid) begin
      case (pkt_idx_q)
        2'd0: begin
          // Status byte must carry the always-one bit; otherwise resync silently.
          if (rx_byte[SYNC]) begin
            l_d  = rx_byte[BTN_L];
            r_d  = rx_byte[BTN_R];
            xs_d = rx_byte[XS];
            ys_d = rx_byte[YS];
            xo_d = rx_byte[XO];
            yo_d = rx_byte[YO];
            pkt_idx_d = 2'd1;
          end
        end
        2'd1: begin
          dx_d      = rx_byte;
          pkt_idx_d = 2'd2;
        end
        default: begin
          xpos_d    = clamp_axis(x_sum, 12'(X_MAX));
          ypos_d    = clamp_axis(y_sum, 12'(Y_MAX));
          left_d    = l_q;
          right_d   = r_q;
          pv_d      = 1'b1;
          pkt_idx_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_idx_q <= 2'd0;
      l_q <= 1'b0;  r_q <= 1'b0;  xs_q <= 1'b0;  ys_q <= 1'b0;  xo_q <= 1'b0;  yo_q <= 1'b0;
      dx_q      <= 8'd0;
      xpos_q    <= 12'(X_INIT);
      ypos_q    <= 12'(Y_INIT);
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      pkt_idx_q <= pkt_idx_d;
      l_q <= l_d;  r_q <= r_d;  xs_q <= xs_d;  ys_q <= ys_d;  xo_q <= xo_d;  yo_q <= yo_d;
      dx_q      <= dx_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      left_q    <= left_d;
      right_q   <= right_d;
      pv_q      <= pv_d;
    end
  end

  assign mouse_xpos   = xpos_q;
  assign mouse_ypos   = ypos_q;
  assign left_mouse   = left_q;
  assign right_mouse  = right_q;
  assign packet_valid = pv_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb_ps2_mouse_decoder: directed + randomized PS/2 byte streams checked
// against a byte-level reference model of the mouse packet protocol.
module tb_ps2_mouse_decoder;

  localparam int X_MAX  = 1023;
  localparam int Y_MAX  = 767;
  localparam int X_INIT = 512;
  localparam int Y_INIT = 384;
  localparam int TMO    = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        left_mouse, right_mouse, packet_valid, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int chg_viol = 0;

  // reference model state
  int         m_x, m_y, m_l, m_r, m_idx, m_pv, m_fe;
  logic [7:0] m_b0, m_b1;

  always #5 clk = ~clk;

  ps2_mouse_decoder #(
    .CLK_FREQ_HZ(65_000_000), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .left_mouse(left_mouse), .right_mouse(right_mouse),
    .packet_valid(packet_valid), .frame_err(frame_err)
  );

  // pulse counters and "outputs only move with packet_valid" watcher
  logic [11:0] px, py;
  logic        pl, pr;
  always @(negedge clk) begin
    if (rst) begin
      if (packet_valid) pv_cnt <= pv_cnt + 1;
      if (frame_err)    fe_cnt <= fe_cnt + 1;
      if (!packet_valid && (mouse_xpos != px || mouse_ypos != py ||
                            left_mouse != pl || right_mouse != pr))
        chg_viol <= chg_viol + 1;
    end
    px <= mouse_xpos; py <= mouse_ypos; pl <= left_mouse; pr <= right_mouse;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  task automatic m_reset();
    m_x = X_INIT; m_y = Y_INIT; m_l = 0; m_r = 0; m_idx = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int dx, dy;
    if (m_idx == 0) begin
      if (b[3]) begin m_b0 = b; m_idx = 1; end
    end else if (m_idx == 1) begin
      m_b1 = b; m_idx = 2;
    end else begin
      dx = m_b0[6] ? 0 : (m_b0[4] ? int'(m_b1) - 256 : int'(m_b1));
      dy = m_b0[7] ? 0 : (m_b0[5] ? int'(b) - 256 : int'(b));
      m_x = clampi(m_x + dx, X_MAX);
      m_y = clampi(m_y - dy, Y_MAX);   // device Y is positive upward
      m_l = int'(m_b0[0]);
      m_r = int'(m_b0[1]);
      m_pv++;
      m_idx = 0;
    end
  endtask

  // device changes data mid-high, host samples on falling clock
  task automatic ps2_bit(input logic b);
    repeat (4) @(posedge clk);
    ps2_data = b;
    repeat (4) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (16) @(posedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b0);
    m_byte(b);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_good(b0); send_good(b1); send_good(b2);
  endtask

  task automatic check_all(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, ".xpos"},  int'(mouse_xpos), m_x);
    chk({tag, ".ypos"},  int'(mouse_ypos), m_y);
    chk({tag, ".left"},  int'(left_mouse), m_l);
    chk({tag, ".right"}, int'(right_mouse), m_r);
    chk({tag, ".pv_cnt"}, pv_cnt, m_pv);
    chk({tag, ".fe_cnt"}, fe_cnt, m_fe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1, b2;
    m_reset(); m_pv = 0; m_fe = 0;
    repeat (5) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_all("reset");

    // 1. +16 in X, left button
    send_pkt(8'h09, 8'h10, 8'h00);
    check_all("t1");
    chk("t1.x_abs", int'(mouse_xpos), 528);

    // 2. Y moves down by 16, then Y clamp at the bottom edge
    send_pkt(8'h28, 8'h00, 8'hF0);
    check_all("t2a");
    chk("t2a.y_abs", int'(mouse_ypos), 400);
    send_pkt(8'h28, 8'h00, 8'h00);   // dy = -256
    send_pkt(8'h28, 8'h00, 8'h98);   // dy = -104 -> 760
    chk("t2b.y760", int'(mouse_ypos), 760);
    send_pkt(8'h28, 8'h00, 8'hEC);   // dy = -20
    check_all("t2c");
    chk("t2c.y_abs", int'(mouse_ypos), Y_MAX);

    // 3. X clamp at zero, then X overflow ignored but packet still valid
    send_pkt(8'h18, 8'h00, 8'h00);   // -256
    send_pkt(8'h18, 8'h00, 8'h00);   // -256 -> 16
    send_pkt(8'h18, 8'hF5, 8'h00);   // -11 -> 5
    chk("t3a.x5", int'(mouse_xpos), 5);
    send_pkt(8'h18, 8'hF6, 8'h00);
    check_all("t3b");
    chk("t3b.x_abs", int'(mouse_xpos), 0);
    send_pkt(8'h4A, 8'h7F, 8'h00);
    check_all("t3c");

    // 4. resync byte without bit3
    send_good(8'h01);
    send_pkt(8'h0A, 8'h05, 8'h03);
    check_all("t4");

    // 5. stall two bits into byte1 until timeout
    send_good(8'h09);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TMO + 100) @(posedge clk);
    m_fe++; m_idx = 0;
    check_all("t5a");
    send_pkt(8'h0B, 8'h20, 8'h10);
    check_all("t5b");

    // 6. byte1 with even parity
    send_good(8'h08);
    send_byte(8'h05, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    m_fe++; m_idx = 0;
`else
    m_byte(8'h05);
`endif
    send_good(8'h00);
    check_all("t6a");
    send_pkt(8'h08, 8'h01, 8'h01);
    check_all("t6b");

    // reset in the middle of a frame
    send_pkt(8'h0B, 8'h33, 8'h44);
    send_good(8'h09);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2_data = 1'b1;
    rst = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid.xpos", int'(mouse_xpos), X_INIT);
    chk("rstmid.ypos", int'(mouse_ypos), Y_INIT);
    chk("rstmid.btn", int'({left_mouse, right_mouse}), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    send_pkt(8'h09, 8'h04, 8'h04);
    check_all("rstmid.after");

    // randomized packets with occasional junk and overflow
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        b0 = 8'($urandom);
        b0[3] = 1'b0;
        send_good(b0);
      end
      b0 = 8'($urandom);
      b0[3] = 1'b1;
      if ($urandom_range(0, 7) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send_pkt(b0, b1, b2);
      if (n % 4 == 3) check_all("rand");
    end
    check_all("final");
    chk("no_spurious_change", chg_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
